// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch-stage state encoding, instruction width and opcode constants shared with the control decoder
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef enum logic [1:0] {RST_WAIT, FETCH, FLUSH} fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO with clear; clear overrides push and pop
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  // next-state for storage, pointers and fill count; a full FIFO only accepts a push alongside a pop
  always_comb begin
    do_pop = pop && count_q != '0;
    do_push = push && (count_q != (AW+1)'(DEPTH) || do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    rd_d = clr ? '0 : rd_q + AW'(do_pop);
    wr_d = clr ? '0 : wr_q + AW'(do_push);
    count_d = clr ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout = mem_q[rd_q];
    count = count_q;
  end
  // storage and pointer registers; entries reset to zero so the head reads 0 after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, request/grant fetch, prefetch FIFO and redirect flush; FETCH_ALIGN_CHECK_EN enables misaligned-redirect trapping
module fetch_unit import fetch_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [6:0]        opcode,
  output logic              misalign
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, tgt_pc, rsp_pc;
  logic [CW-1:0] out_q, out_d, count;
  logic mis_q, mis_d, bad_tgt, grant, rsp, push, pop;
  logic [INSTR_W+ADDR_W-1:0] head;
  // Responses arrive in order and every request outstanding in FETCH is sequential from the last
  // redirect, so the oldest in-flight PC is pc minus four per outstanding request.
  always_comb begin
`ifdef FETCH_ALIGN_CHECK_EN
    tgt_pc = redirect_pc;
    bad_tgt = redirect_pc[1:0] != 2'b00;
`else
    tgt_pc = redirect_pc & ~ADDR_W'(3);
    bad_tgt = 1'b0;
`endif
    imem_req = state_q == FETCH && ({1'b0, count} + {1'b0, out_q}) < (CW+1)'(DEPTH);
    imem_addr = pc_q;
    grant = imem_req && imem_gnt;
    rsp = imem_rvalid && out_q != '0;
    rsp_pc = pc_q - ADDR_W'({out_q, 2'b00});
    push = rsp && state_q == FETCH && !redirect;
    instr_valid = count != '0;
    pop = instr_valid && instr_ready;
    out_d = out_q + CW'(grant) - CW'(rsp);
    pc_d = redirect ? tgt_pc : grant ? pc_q + ADDR_W'(4) : pc_q;
    mis_d = redirect ? bad_tgt : mis_q;
    state_d = redirect ? ((out_d != '0 || bad_tgt) ? FLUSH : FETCH)
            : state_q == RST_WAIT ? FETCH
            : (state_q == FLUSH && out_d == '0 && !mis_q) ? FETCH : state_q;
    {instr, instr_pc} = head;
    opcode = instr[6:0];
    misalign = mis_q;
  end
  // control state: FSM, program counter, in-flight count and sticky misalign flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_WAIT;
      pc_q <= RESET_PC;
      out_q <= '0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      out_q <= out_d;
      mis_q <= mis_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .W(INSTR_W + ADDR_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (redirect),
    .push  (push),
    .pop   (pop),
    .din   ({imem_rdata, rsp_pc}),
    .dout  (head),
    .count (count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit against a queue-based memory and instruction-stream model
module tb_fetch_unit;
  localparam int DEPTH = 2;
  logic clk = 0, rst_n = 0;
  logic imem_req, imem_gnt = 0, imem_rvalid = 0, redirect = 0, instr_valid, instr_ready = 0, misalign;
  logic [31:0] imem_addr, imem_rdata = 0, redirect_pc = 0, instr, instr_pc;
  logic [6:0] opcode;
  int passed = 0, total = 0;
  int cyc = 0, edges = 0, live = 0, stale = 0, pops = 0;
  bit mis = 0, redir_prev = 0, wrapped = 0;
  logic [31:0] fpc = 0, npc = 0, last_pop_pc = 0, last_grant = 0;
  logic [31:0] memq_a[$];
  int memq_d[$];

  fetch_unit #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 32'h0 ? 32'h0000_0033 : (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else passed++;
  endtask

  task automatic do_reset();
    rst_n = 0; imem_gnt = 0; imem_rvalid = 0; redirect = 0; instr_ready = 0;
    #1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_misalign", misalign, 0);
    memq_a.delete(); memq_d.delete();
    live = 0; stale = 0; mis = 0; fpc = 0; npc = 0; redir_prev = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1; edges = 0;
  endtask

  // one cycle, entered and left at a falling edge: check outputs, drive inputs, advance the model
  task automatic step(input bit rd, input logic [31:0] rpc, input int gp, input int rp, input int vp);
    bit g, p, v, exp_req;
    int buf_n;
    logic [31:0] w, tgt;
    buf_n = live - (memq_a.size() - stale);
    exp_req = edges >= 1 && !mis && stale == 0 && live < DEPTH;
    check("req", imem_req, exp_req);
    check("valid", instr_valid, buf_n > 0);
    check("misalign", misalign, mis);
    if (redir_prev) check("valid_after_redirect", instr_valid, 0);
    imem_gnt = $urandom_range(99) < gp;
    instr_ready = $urandom_range(99) < rp;
    v = memq_a.size() > 0 && memq_d[0] <= cyc && $urandom_range(99) < vp;
    imem_rvalid = v;
    imem_rdata = v ? mem_word(memq_a[0]) : $urandom();
    redirect = rd; redirect_pc = rpc;
    g = imem_req && imem_gnt;
    p = instr_valid && instr_ready;
    if (g) begin
      check("imem_addr", imem_addr, fpc);
      if (imem_addr == 32'h0 && last_grant == 32'hFFFF_FFFC) wrapped = 1;
      last_grant = imem_addr;
      memq_a.push_back(imem_addr);
      memq_d.push_back(cyc + 1 + $urandom_range(2));
      fpc += 4; live++;
    end
    if (p) begin
      w = mem_word(npc);
      check("instr_pc", instr_pc, npc);
      check("instr", instr, w);
      check("opcode", opcode, w[6:0]);
      if (npc == 32'h0) check("opcode_r", opcode, 7'b0110011);
      last_pop_pc = instr_pc;
      npc += 4; live--; pops++;
    end
    if (v) begin
      void'(memq_a.pop_front()); void'(memq_d.pop_front());
      if (stale > 0) stale--;
    end
    if (rd) begin
`ifdef FETCH_ALIGN_CHECK_EN
      tgt = rpc; mis = rpc[1:0] != 2'b00;
`else
      tgt = rpc & ~32'h3; mis = 0;
`endif
      stale = memq_a.size(); live = 0; fpc = tgt; npc = tgt;
    end
    redir_prev = rd;
    @(posedge clk);
    cyc++; edges++;
    @(negedge clk);
    redirect = 0;
  endtask

  initial begin
    int n, p0;
    bit hit;
    logic [31:0] r;
    @(negedge clk);
    do_reset();
    // streaming with a single-cycle memory
    for (int i = 0; i < 30; i++) step(0, 0, 100, 100, 100);
    check("stream_progress", pops > 10, 1);
    // decode stalls: requests must stop at DEPTH, nothing lost on resume
    for (int i = 0; i < 10; i++) step(0, 0, 100, 0, 100);
    for (int i = 0; i < 20; i++) step(0, 0, 100, 100, 100);
    // build two outstanding requests, then redirect to 0x100
    for (int i = 0; i < 6; i++) step(0, 0, 0, 100, 100);
    n = 0;
    while (memq_a.size() < 2 && n < 10) begin step(0, 0, 100, 0, 0); n++; end
    check("two_outstanding", memq_a.size(), 2);
    step(1, 32'h100, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 100, 0, 0);
    p0 = pops; n = 0;
    while (pops == p0 && n < 50) begin step(0, 0, 100, 100, 100); n++; end
    check("redirect_head_pc", last_pop_pc, 32'h100);
    // redirect coinciding with a pop and a live response
    hit = 0; n = 0;
    while (!hit && n < 200) begin
      if (instr_valid && memq_a.size() > stale && memq_d[0] <= cyc) begin
        step(1, 32'h40, 0, 100, 100); hit = 1;
      end else step(0, 0, 100, 30, 50);
      n++;
    end
    check("redir_pop_rvalid_hit", hit, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 100, 100, 100);
    // PC wrap at the top of the address space
    step(1, 32'hFFFF_FFF4, 100, 100, 100);
    for (int i = 0; i < 30; i++) step(0, 0, 100, 100, 100);
    check("wrap_seen", wrapped, 1);
    // misaligned redirect target
    step(1, 32'h102, 100, 100, 100);
    for (int i = 0; i < 5; i++) step(0, 0, 100, 100, 100);
`ifdef FETCH_ALIGN_CHECK_EN
    check("misalign_set", misalign, 1);
`else
    check("misalign_set", misalign, 0);
`endif
    step(1, 32'h200, 100, 100, 100);
    p0 = pops; n = 0;
    while (pops == p0 && n < 50) begin step(0, 0, 100, 100, 100); n++; end
    check("resume_200", last_pop_pc, 32'h200);
    // randomized traffic with occasional redirects
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(3) == 0 ? 32'hFFFF_FFF8 : {$urandom_range(16'hFFFF), 2'b00};
      if ($urandom_range(9) == 0) r[1:0] = 2'($urandom_range(3));
      step($urandom_range(99) < 3, r, $urandom_range(20, 100), $urandom_range(20, 100), $urandom_range(20, 100));
    end
    // reset in the middle of traffic
    for (int i = 0; i < 5; i++) step(0, 0, 100, 0, 0);
    do_reset();
    for (int i = 0; i < 40; i++) step(0, 0, 100, 100, 100);
    check("progress", pops > 200, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
